// File: rtl/bufz_pkg.sv
// bufz_pkg: shared FSM encoding, parameter limits and
// turn-counter width for the bufz tri-state bus arbiter.
package bufz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int NCH_MIN   = 2;
  localparam int NCH_MAX   = 16;
  localparam int TURN_MIN  = 0;
  localparam int TURN_MAX  = 7;

  // Counter wide enough for the largest turnaround.
  localparam int TCW = $clog2(TURN_MAX + 1);

endpackage

// File: rtl/bufz_bus_arb_if.sv
// bufz_bus_arb_if: requester-side bundle of the arbiter.
// master drives EN/REQ/D, slave returns GNT/OE/BUSY.
interface bufz_bus_arb_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  logic                 EN;
  logic [NCH-1:0]       REQ;
  logic [NCH*WIDTH-1:0] D;
  logic [NCH-1:0]       GNT;
  logic                 OE;
  logic                 BUSY;

  modport master (
    output EN, REQ, D,
    input  GNT, OE, BUSY
  );

  modport slave (
    input  EN, REQ, D,
    output GNT, OE, BUSY
  );
endinterface

// File: rtl/bufz_rr_arb.sv
// bufz_rr_arb: combinational round-robin pick.
// i_req/i_ptr in, one-hot o_gnt (first req at/after ptr).
module bufz_rr_arb #(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt
);

  logic [NCH-1:0] w_rot;
  logic [NCH-1:0] w_pick;

  // Rotate so the pointer sits at bit 0, take the
  // lowest set bit, then rotate the pick back.
  assign w_rot  = NCH'({i_req, i_req} >> i_ptr);
  assign w_pick = w_rot & (~w_rot + NCH'(1));
  assign o_gnt  =
    NCH'(({w_pick, w_pick} << i_ptr) >> NCH);

endmodule

// File: rtl/bufz_bus_arb.sv
// bufz_bus_arb: round-robin owner of a tri-state bus.
// CLK/RN, EN/REQ/D in; GNT/OE/BUSY out; Z bus; VDD/VSS.
module bufz_bus_arb
  import bufz_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int TURN  = 1
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 EN,
  input  logic [NCH-1:0]       REQ,
  input  logic [NCH*WIDTH-1:0] D,
  output logic [NCH-1:0]       GNT,
  output logic                 OE,
  output logic                 BUSY,
  output wire  [WIDTH-1:0]     Z,
  inout  wire                  VDD,
  inout  wire                  VSS
);

  localparam int PW = $clog2(NCH);
  localparam logic [TCW-1:0] TLAST =
    TCW'((TURN > 0) ? TURN - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [NCH-1:0]   r_gnt, w_gnt_nxt, w_win;
  logic             r_oe, w_oe_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt, w_own;
  logic [TCW-1:0]   r_cnt, w_cnt_nxt;
  logic             w_any, w_keep;
  logic             w_unused;

  function automatic logic [WIDTH-1:0] f_sel(
    input logic [NCH-1:0]       oh,
    input logic [NCH*WIDTH-1:0] d
  );
    logic [WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++)
      if (oh[k]) v |= d[k*WIDTH +: WIDTH];
    return v;
  endfunction

  function automatic logic [PW-1:0] f_idx(
    input logic [NCH-1:0] oh
  );
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++)
      if (oh[k]) v |= PW'(k);
    return v;
  endfunction

  bufz_rr_arb #(
    .NCH (NCH),
    .PW  (PW)
  ) u_arb (
    .i_req (REQ),
    .i_ptr (r_ptr),
    .o_gnt (w_win)
  );

  assign w_any    = EN && (|REQ);
  assign w_keep   = |(REQ & r_gnt);
  assign w_own    = f_idx(r_gnt);
  assign w_unused = ^{VDD, VSS};

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_oe_nxt    = r_oe;
    w_data_nxt  = r_data;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_win;
          w_oe_nxt    = 1'b1;
          w_data_nxt  = f_sel(w_win, D);
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (w_keep) begin
          w_data_nxt = f_sel(r_gnt, D);
        end else begin
          w_gnt_nxt   = '0;
          w_oe_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (w_own == PW'(NCH - 1)) ?
                        '0 : w_own + PW'(1);
          w_state_nxt = (TURN > 0) ? ST_TURN : ST_IDLE;
        end
      end
      ST_TURN: begin
        if (r_cnt != TLAST) begin
          w_cnt_nxt = r_cnt + TCW'(1);
        end else if (w_any) begin
          // Last dead cycle: arbitrate on the closing edge
          // so the gap is exactly TURN cycles.
          w_cnt_nxt   = '0;
          w_gnt_nxt   = w_win;
          w_oe_nxt    = 1'b1;
          w_data_nxt  = f_sel(w_win, D);
          w_state_nxt = ST_DRIVE;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_oe_nxt    = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_oe    <= 1'b0;
      r_data  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_oe    <= w_oe_nxt;
      r_data  <= w_data_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign GNT  = r_gnt;
  assign OE   = r_oe;
  assign BUSY = (r_state != ST_IDLE);

  // EN gates the driver directly, no register in path.
  assign Z = (r_oe && EN) ? r_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bufz_bus_arb.sv
// tb_bufz_bus_arb: directed scoreboard bench for three
// configurations (default, TURN=0, NCH=2/WIDTH=1/TURN=7).
module tb_bufz_bus_arb;

  logic clk = 1'b0;
  logic rn;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;
  wire [7:0] z0;
  wire [7:0] z1;
  wire [0:0] z2;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          dut;
    string       tag;
    logic [15:0] gnt;
    logic        oe;
    logic        busy;
    logic [63:0] z;
  } exp_t;

  exp_t sb[$];

  bufz_bus_arb_if #(.WIDTH(8), .NCH(4)) b0();
  bufz_bus_arb_if #(.WIDTH(8), .NCH(4)) b1();
  bufz_bus_arb_if #(.WIDTH(1), .NCH(2)) b2();

  bufz_bus_arb #(.WIDTH(8), .NCH(4), .TURN(1)) u0 (
    .CLK(clk), .RN(rn), .EN(b0.EN), .REQ(b0.REQ),
    .D(b0.D), .GNT(b0.GNT), .OE(b0.OE),
    .BUSY(b0.BUSY), .Z(z0), .VDD(vdd), .VSS(vss)
  );

  bufz_bus_arb #(.WIDTH(8), .NCH(4), .TURN(0)) u1 (
    .CLK(clk), .RN(rn), .EN(b1.EN), .REQ(b1.REQ),
    .D(b1.D), .GNT(b1.GNT), .OE(b1.OE),
    .BUSY(b1.BUSY), .Z(z1), .VDD(vdd), .VSS(vss)
  );

  bufz_bus_arb #(.WIDTH(1), .NCH(2), .TURN(7)) u2 (
    .CLK(clk), .RN(rn), .EN(b2.EN), .REQ(b2.REQ),
    .D(b2.D), .GNT(b2.GNT), .OE(b2.OE),
    .BUSY(b2.BUSY), .Z(z2), .VDD(vdd), .VSS(vss)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] zz(int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = 1'bz;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int dut, string tag,
                      logic [15:0] gnt, logic oe,
                      logic busy, logic [63:0] z);
    exp_t e;
    e.dut  = dut;
    e.tag  = tag;
    e.gnt  = gnt;
    e.oe   = oe;
    e.busy = busy;
    e.z    = z;
    sb.push_back(e);
  endtask

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [15:0] og;
    logic        oo;
    logic        ob;
    logic [63:0] oz;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    case (e.dut)
      0: begin
        og = {12'b0, b0.GNT}; oo = b0.OE;
        ob = b0.BUSY; oz = {56'b0, z0};
      end
      1: begin
        og = {12'b0, b1.GNT}; oo = b1.OE;
        ob = b1.BUSY; oz = {56'b0, z1};
      end
      default: begin
        og = {14'b0, b2.GNT}; oo = b2.OE;
        ob = b2.BUSY; oz = {63'b0, z2};
      end
    endcase
    chk({e.tag, "_gnt"}, 64'(og), 64'(e.gnt));
    chk({e.tag, "_oe"}, 64'(oo), 64'(e.oe));
    chk({e.tag, "_busy"}, 64'(ob), 64'(e.busy));
    chk({e.tag, "_z"}, oz, e.z);
  endtask

  task automatic do_reset();
    rn = 1'b0;
    #2;
    rn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dv [4];
    int k;
    dv = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    rn = 1'b0;
    b0.EN = 1'b1; b0.REQ = '0; b0.D = '0;
    b1.EN = 1'b1; b1.REQ = '0; b1.D = '0;
    b2.EN = 1'b1; b2.REQ = '0; b2.D = '0;
    #3;
    push(0, "rst0", 0, 0, 0, zz(8)); pop_check();
    push(1, "rst1", 0, 0, 0, zz(8)); pop_check();
    push(2, "rst2", 0, 0, 0, zz(1)); pop_check();
    tick();
    rn = 1'b1;

    // single request, one-cycle D-to-Z latency
    b0.REQ = 4'b0001;
    b0.D = {8'h44, 8'h33, 8'h22, 8'hA5};
    push(0, "a_idle", 0, 0, 0, zz(8)); pop_check();
    push(0, "a_grant", 1, 1, 1, 64'hA5);
    tick(); pop_check();
    b0.D[7:0] = 8'h5A;
    push(0, "a_old", 1, 1, 1, 64'hA5); pop_check();
    push(0, "a_new", 1, 1, 1, 64'h5A);
    tick(); pop_check();
    b0.REQ = '0;
    push(0, "a_rel", 0, 0, 1, zz(8));
    tick(); pop_check();
    push(0, "a_idle2", 0, 0, 0, zz(8));
    tick(); pop_check();

    // round robin over all four, one dead cycle each
    do_reset();
    b0.D = {dv[3], dv[2], dv[1], dv[0]};
    b0.REQ = 4'hF;
    for (int n = 0; n < 5; n++) begin
      k = n % 4;
      push(0, "rr_grant", 16'(1 << k), 1, 1,
           64'(dv[k]));
      tick(); pop_check();
      repeat (2) begin
        push(0, "rr_hold", 16'(1 << k), 1, 1,
             64'(dv[k]));
        tick(); pop_check();
      end
      b0.REQ[k] = 1'b0;
      push(0, "rr_turn", 0, 0, 1, zz(8));
      tick(); pop_check();
      b0.REQ = (n == 4) ? 4'h0 : 4'hF;
    end
    push(0, "rr_idle", 0, 0, 0, zz(8));
    tick(); pop_check();

    // EN low floats Z at once, ownership kept
    do_reset();
    b0.REQ = 4'b0010;
    b0.D = {8'h00, 8'h00, 8'h3C, 8'h00};
    push(0, "c_grant", 2, 1, 1, 64'h3C);
    tick(); pop_check();
    b0.EN = 1'b0;
    #1;
    push(0, "c_en_off", 2, 1, 1, zz(8)); pop_check();
    b0.D[15:8] = 8'h96;
    push(0, "c_en_hold", 2, 1, 1, zz(8));
    tick(); pop_check();
    b0.EN = 1'b1;
    #1;
    push(0, "c_en_on", 2, 1, 1, 64'h96); pop_check();
    b0.REQ = '0;
    push(0, "c_rel", 0, 0, 1, zz(8));
    tick(); pop_check();
    push(0, "c_idle", 0, 0, 0, zz(8));
    tick(); pop_check();

    // EN low blocks grants, then reset mid-drive
    b0.EN = 1'b0;
    b0.REQ = 4'b0100;
    b0.D[23:16] = 8'h69;
    push(0, "d_en_blk", 0, 0, 0, zz(8));
    tick(); pop_check();
    b0.EN = 1'b1;
    push(0, "d_g2", 4, 1, 1, 64'h69);
    tick(); pop_check();
    rn = 1'b0;
    #1;
    push(0, "d_rst_async", 0, 0, 0, zz(8)); pop_check();
    push(0, "d_rst_hold", 0, 0, 0, zz(8));
    tick(); pop_check();
    rn = 1'b1;
    b0.REQ = 4'b1001;
    b0.D[7:0] = 8'h11;
    b0.D[31:24] = 8'h88;
    push(0, "d_ptr0", 1, 1, 1, 64'h11);
    tick(); pop_check();
    b0.REQ = '0;
    push(0, "d_rel", 0, 0, 1, zz(8));
    tick(); pop_check();

    // TURN=0: one IDLE cycle between owners
    b1.D = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
    b1.REQ = 4'b0100;
    push(1, "e_g2", 4, 1, 1, 64'hE2);
    tick(); pop_check();
    b1.REQ = 4'b1100;
    push(1, "e_hold", 4, 1, 1, 64'hE2);
    tick(); pop_check();
    b1.REQ = 4'b1000;
    push(1, "e_idle", 0, 0, 0, zz(8));
    tick(); pop_check();
    push(1, "e_g3", 8, 1, 1, 64'hE3);
    tick(); pop_check();
    b1.REQ = '0;
    push(1, "e_rel3", 0, 0, 0, zz(8));
    tick(); pop_check();
    b1.EN = 1'b0;
    b1.REQ = 4'b0001;
    push(1, "e_en_blk", 0, 0, 0, zz(8));
    tick(); pop_check();
    b1.EN = 1'b1;
    push(1, "e_g0", 1, 1, 1, 64'hE0);
    tick(); pop_check();
    b1.REQ = '0;

    // NCH=2 WIDTH=1 TURN=7: seven busy dead cycles
    b2.D = 2'b11;
    b2.REQ = 2'b01;
    push(2, "f_g0", 1, 1, 1, 64'h1);
    tick(); pop_check();
    b2.REQ = 2'b10;
    for (int i = 0; i < 7; i++) begin
      push(2, "f_dead", 0, 0, 1, zz(1));
      tick(); pop_check();
    end
    push(2, "f_g1", 2, 1, 1, 64'h1);
    tick(); pop_check();
    b2.REQ = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bufz_bus_arb.md
BUFZ_BUS_ARB -- requirements
Module: bufz_bus_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bus data width in bits (legal range 1..64).
REQ-002 SHALL have parameter NCH, default 4, giving the number of requesting channels (legal range 2..16).
REQ-003 SHALL have parameter TURN, default 1, giving the bus-turnaround dead cycles after a release (legal range 0..7).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock, all state updated on its rising edge.
REQ-005 SHALL have port RN, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port EN, input, 1 bit: global output enable; low forces Z to high-Z and blocks new grants.
REQ-007 SHALL have port REQ, input, NCH bits: per-channel bus request, level-sensitive.
REQ-008 SHALL have port D, input, NCH*WIDTH bits: channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port GNT, output, NCH bits: one-hot registered grant, all-zero when no owner.
REQ-010 SHALL have port OE, output, 1 bit: registered drive-valid flag.
REQ-011 SHALL have port BUSY, output, 1 bit: high in DRIVE or TURN states.
REQ-012 SHALL have port Z, output, WIDTH bits: tri-state bus output.
REQ-013 SHALL have ports VDD and VSS, inout, 1 bit each: supply pins, no logic function.

Function
REQ-014 SHALL implement states IDLE, DRIVE, TURN.
REQ-015 SHALL, in IDLE with EN=1 and any REQ bit high, grant on the next edge the first requesting channel at or after the round-robin pointer (wrapping from NCH-1 to 0), set GNT one-hot, OE=1, data register = D of winner, and enter DRIVE.
REQ-016 SHALL, in IDLE with EN=0 or REQ all-zero, hold GNT=0 and OE=0.
REQ-017 SHALL, in DRIVE while REQ[owner]=1, reload the data register from D[owner] every edge (one-cycle D-to-Z latency), ignoring other REQ bits.
REQ-018 SHALL, in DRIVE when REQ[owner]=0 at an edge, clear GNT and OE, set pointer to owner+1 mod NCH, and enter TURN (TURN>0) or IDLE (TURN=0).
REQ-019 SHALL, in TURN, count TURN cycles with OE=0 and GNT=0, then enter IDLE; new requests are not granted during TURN.
REQ-020 SHALL drive Z = data register when OE=1 and EN=1, else high-Z (all bits), EN acting combinationally.
REQ-021 SHALL, when EN falls during DRIVE, keep the owner and state but float Z immediately; ownership continues until REQ[owner] drops.
REQ-022 SHALL guarantee at most one GNT bit high, and no cycle in which Z is driven from two different owners (break-before-make).
REQ-023 SHALL treat simultaneous requests by the round-robin pointer only; a channel released at pointer p has lowest priority in the next arbitration.

Reset
REQ-024 SHALL, while RN=0, asynchronously force state IDLE, GNT=0, OE=0, BUSY=0, data register=0, pointer=0, turn counter=0, Z high-Z.
REQ-025 SHALL, on RN assertion mid-DRIVE or mid-TURN, abandon the transaction with no grant resumed after release.
REQ-026 SHALL resume normal arbitration on the first rising CLK edge after RN deasserts.

Structure
REQ-027 SHALL place the state enumeration and the WIDTH/NCH/TURN legal-range constants in shared package bufz_pkg.
REQ-028 SHALL implement arbitration in one sub-module, bufz_rr_arb (NCH-wide request/pointer in, one-hot winner out, combinational).
REQ-029 SHALL keep all tri-state logic in the top level, assigned to Z only.

Verification
REQ-030 SHALL cover: reset, REQ=4'b0001, D0=8'hA5 -> GNT=0001 and Z=8'hA5 one edge later, OE=1, BUSY=1.
REQ-031 SHALL cover: REQ=4'b1111 held, each owner dropping after 3 cycles, TURN=1 -> grant order 0,1,2,3,0 with exactly 1 high-Z cycle between owners.
REQ-032 SHALL cover: EN=0 during DRIVE -> Z=8'hZZ same cycle, GNT unchanged; EN=1 -> Z resumes current D of owner.
REQ-033 SHALL cover: RN pulsed low mid-DRIVE -> GNT=0, OE=0, Z high-Z immediately, pointer back to 0.
REQ-034 SHALL cover: TURN=0, owner 2 drops while REQ[3]=1 -> IDLE one cycle, then GNT=1000, never two GNT bits high.
REQ-035 SHALL cover: NCH=2, WIDTH=1, TURN=7 -> 7 dead cycles after release, BUSY high throughout.
